led_pattern_sequencer: RTL and testbench

Parametrised LED pattern engine driving a W-bit LED bank from a register advanced by an internal programmable-period divider. It replaces the fixed power-of-two prescaler plus single-direction rotator with runtime-selectable rotate-left, rotate-right, bounce and blink modes, parallel pattern load, and enable/pause control. It sits between board LED pins and optional control logic (buttons, UART, or tie-offs).

---
 rtl/led_pattern_sequencer_if.sv | 25 ++
 rtl/led_pattern_sequencer.sv | 88 ++++++++
 tb/tb_led_pattern_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/led_pattern_sequencer_if.sv
// Control and status bundle between an LED pattern engine and whatever drives it
// (buttons, UART bridge, or tie-offs).
interface led_pattern_sequencer_if #(
    parameter int W        = 8,
    parameter int DIV_BITS = 24
);
    logic                en;
    logic [1:0]          mode;
    logic                load;
    logic [W-1:0]        pattern;
    logic [DIV_BITS-1:0] period;
    logic [W-1:0]        leds;
    logic                step;
    logic                dir;

    modport master (
        output en, mode, load, pattern, period,
        input  leds, step, dir
    );

    modport slave (
        input  en, mode, load, pattern, period,
        output leds, step, dir
    );
endinterface

// File: rtl/led_pattern_sequencer.sv
// LED pattern engine: programmable-period divider advancing a W-bit pattern
// register in rotate-left, rotate-right, bounce or blink mode.
//
// dir state | meaning
// ----------+--------------------------------------
// DIR_UP    | bounce moving toward MSB (shift left)
// DIR_DOWN  | bounce moving toward LSB (shift right)
module led_pattern_sequencer #(
    parameter int           W        = 8,
    parameter int           DIV_BITS = 24,
    parameter logic [W-1:0] INIT     = W'(1)
) (
    input logic                  CLK,
    input logic                  RSTN,
    led_pattern_sequencer_if.slave bus
);
    localparam logic [1:0] MODE_ROTL   = 2'b00;
    localparam logic [1:0] MODE_ROTR   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic       DIR_UP      = 1'b0;
    localparam logic       DIR_DOWN    = 1'b1;

    logic [DIV_BITS-1:0] cnt_q;
    logic [W-1:0]        leds_q;
    logic [W-1:0]        leds_nxt;
    logic                dir_q;
    logic                dir_nxt;
    logic                step_q;
    logic                tick;

    // >= rather than == so a period lowered below the running count fires at once.
    assign tick = bus.en && (cnt_q >= bus.period);

    always_comb begin
        leds_nxt = leds_q;
        dir_nxt  = dir_q;
        case (bus.mode)
            MODE_ROTL: leds_nxt = {leds_q[W-2:0], leds_q[W-1]};
            MODE_ROTR: leds_nxt = {leds_q[0], leds_q[W-1:1]};
            MODE_BOUNCE: begin
                if (dir_q == DIR_UP) begin
                    if (leds_q[W-1]) begin
                        dir_nxt  = DIR_DOWN;
                        leds_nxt = leds_q >> 1;
                    end else begin
                        leds_nxt = leds_q << 1;
                    end
                end else begin
                    if (leds_q[0]) begin
                        dir_nxt  = DIR_UP;
                        leds_nxt = leds_q << 1;
                    end else begin
                        leds_nxt = leds_q >> 1;
                    end
                end
            end
            default: leds_nxt = ~leds_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cnt_q  <= '0;
            leds_q <= INIT;
            dir_q  <= DIR_UP;
            step_q <= 1'b0;
        end else if (bus.load) begin
            cnt_q  <= '0;
            leds_q <= bus.pattern;
            dir_q  <= DIR_UP;
            step_q <= 1'b0;
        end else if (tick) begin
            cnt_q  <= '0;
            leds_q <= leds_nxt;
            dir_q  <= dir_nxt;
            step_q <= 1'b1;
        end else begin
            if (bus.en) begin
                cnt_q <= cnt_q + DIV_BITS'(1);
            end
            step_q <= 1'b0;
        end
    end

    assign bus.leds = leds_q;
    assign bus.step = step_q;
    assign bus.dir  = dir_q;
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer: vector table, directed
// multi-cycle sequences, and randomized stimulus against an arithmetic model.
module tb_led_pattern_sequencer;
    localparam int W        = 8;
    localparam int DIV_BITS = 24;
    localparam int FULL     = 1 << W;

    logic CLK  = 1'b0;
    logic RSTN = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    led_pattern_sequencer_if #(.W(W), .DIV_BITS(DIV_BITS)) bus ();

    led_pattern_sequencer #(.W(W), .DIV_BITS(DIV_BITS), .INIT(8'h01)) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        en;
        logic [1:0]  mode;
        logic        ld;
        logic [7:0]  pat;
        logic [23:0] per;
        logic [7:0]  e_leds;
        logic        e_step;
        logic        e_dir;
    } vec_t;

    vec_t tbl [17];

    // model state: pattern as an integer, elapsed enabled cycles since last step/load
    int m_leds;
    int m_dir;
    int m_step;
    int m_elapsed;

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [1:0] md, input logic ld,
                         input logic [7:0] pat, input logic [23:0] per);
        bus.en      = en;
        bus.mode    = md;
        bus.load    = ld;
        bus.pattern = pat;
        bus.period  = per;
    endtask

    task automatic edge_wait();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_edge(input logic en, input logic [1:0] md, input logic ld,
                              input int pat, input int per);
        if (ld) begin
            m_leds = pat; m_dir = 0; m_step = 0; m_elapsed = 0;
        end else if (!en) begin
            m_step = 0;
        end else if (m_elapsed >= per) begin
            m_elapsed = 0;
            m_step    = 1;
            case (md)
                2'd0: m_leds = (m_leds * 2) % FULL + m_leds / (FULL / 2);
                2'd1: m_leds = m_leds / 2 + (m_leds % 2) * (FULL / 2);
                2'd2: begin
                    if (m_dir == 0) begin
                        if (m_leds >= FULL / 2) begin m_dir = 1; m_leds = m_leds / 2; end
                        else m_leds = (m_leds * 2) % FULL;
                    end else begin
                        if (m_leds % 2 == 1) begin m_dir = 0; m_leds = (m_leds * 2) % FULL; end
                        else m_leds = m_leds / 2;
                    end
                end
                default: m_leds = FULL - 1 - m_leds;
            endcase
        end else begin
            m_elapsed++;
            m_step = 0;
        end
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 8'h00, 24'd0);
        @(negedge CLK);
        @(negedge CLK);
        chk("reset_leds", bus.leds, 8'h01);
        chk("reset_step", bus.step, 0);
        chk("reset_dir",  bus.dir,  0);
        RSTN = 1'b1;
    endtask

    initial begin
        logic       r_en, r_ld;
        logic [1:0] r_md;
        logic [7:0] r_pat;
        int         r_per;
        int         e;

        tbl[0]  = '{1'b1, 2'b01, 1'b0, 8'h00, 24'd0, 8'h80, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 2'b01, 1'b0, 8'h00, 24'd0, 8'h40, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 2'b01, 1'b0, 8'h00, 24'd0, 8'h20, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 2'b11, 1'b1, 8'h0F, 24'd0, 8'h0F, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 2'b11, 1'b0, 8'h00, 24'd0, 8'hF0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 2'b11, 1'b0, 8'h00, 24'd0, 8'h0F, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 2'b10, 1'b1, 8'h00, 24'd0, 8'h00, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 2'b10, 1'b0, 8'h00, 24'd0, 8'h00, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 2'b11, 1'b0, 8'h00, 24'd0, 8'hFF, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 2'b11, 1'b0, 8'h00, 24'd0, 8'hFF, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 2'b11, 1'b1, 8'h80, 24'd0, 8'h80, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 2'b10, 1'b0, 8'h00, 24'd0, 8'h40, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 2'b00, 1'b0, 8'h00, 24'd0, 8'h80, 1'b1, 1'b1};
        tbl[13] = '{1'b1, 2'b10, 1'b0, 8'h00, 24'd0, 8'h40, 1'b1, 1'b1};
        tbl[14] = '{1'b1, 2'b01, 1'b0, 8'h00, 24'd2, 8'h40, 1'b0, 1'b1};
        tbl[15] = '{1'b1, 2'b10, 1'b1, 8'h81, 24'd0, 8'h81, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 2'b10, 1'b0, 8'h00, 24'd0, 8'h40, 1'b1, 1'b1};

        // vector table, starting from reset state
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].en, tbl[i].mode, tbl[i].ld, tbl[i].pat, tbl[i].per);
            edge_wait();
            chk($sformatf("tbl%0d_leds", i), bus.leds, tbl[i].e_leds);
            chk($sformatf("tbl%0d_step", i), bus.step, tbl[i].e_step);
            chk($sformatf("tbl%0d_dir",  i), bus.dir,  tbl[i].e_dir);
        end

        // rotate left, period 3: one step every 4 cycles, wraps after 8 steps
        do_reset();
        drive(1'b1, 2'b00, 1'b0, 8'h00, 24'd3);
        for (int k = 1; k <= 8; k++) begin
            for (int c = 0; c < 3; c++) begin
                edge_wait();
                chk($sformatf("rotl_hold%0d_%0d", k, c), bus.leds, 1 << ((k - 1) % 8));
                chk($sformatf("rotl_nostep%0d_%0d", k, c), bus.step, 0);
            end
            edge_wait();
            chk($sformatf("rotl_step%0d_leds", k), bus.leds, 1 << (k % 8));
            chk($sformatf("rotl_step%0d_step", k), bus.step, 1);
        end

        // full bounce cycle from 0x01, period 0
        drive(1'b1, 2'b10, 1'b1, 8'h01, 24'd0);
        edge_wait();
        bus.load = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            edge_wait();
            e = ((k % 14) <= 7) ? (k % 14) : (14 - (k % 14));
            chk($sformatf("bounce%0d_leds", k), bus.leds, 1 << e);
            chk($sformatf("bounce%0d_dir", k), bus.dir, (k >= 8 && k <= 14) ? 1 : 0);
        end

        // load mid-count with period 9, then freeze and load while disabled
        drive(1'b1, 2'b00, 1'b1, 8'h01, 24'd9);
        edge_wait();
        bus.load = 1'b0;
        repeat (6) edge_wait();
        drive(1'b1, 2'b00, 1'b1, 8'hA5, 24'd9);
        edge_wait();
        chk("midload_leds", bus.leds, 8'hA5);
        chk("midload_step", bus.step, 0);
        bus.load = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            edge_wait();
            chk($sformatf("midload_hold%0d", c), bus.leds + 256 * bus.step, 8'hA5);
        end
        edge_wait();
        chk("midload_next_leds", bus.leds, 8'h4B);
        chk("midload_next_step", bus.step, 1);
        bus.en = 1'b0;
        for (int c = 0; c < 20; c++) begin
            edge_wait();
            chk($sformatf("freeze%0d", c), bus.leds + 256 * bus.step, 8'h4B);
        end
        drive(1'b0, 2'b00, 1'b1, 8'h3C, 24'd9);
        edge_wait();
        chk("load_disabled", bus.leds, 8'h3C);
        bus.load = 1'b0;

        // async reset mid-bounce at leds=0x20, dir=1
        drive(1'b1, 2'b10, 1'b1, 8'h01, 24'd0);
        edge_wait();
        bus.load = 1'b0;
        repeat (9) edge_wait();
        chk("prerst_leds", bus.leds, 8'h20);
        chk("prerst_dir", bus.dir, 1);
        #2;
        RSTN = 1'b0;
        #1;
        chk("arst_leds", bus.leds, 8'h01);
        chk("arst_dir", bus.dir, 0);
        chk("arst_step", bus.step, 0);
        @(negedge CLK);
        drive(1'b1, 2'b00, 1'b0, 8'h00, 24'd3);
        RSTN = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            edge_wait();
            chk($sformatf("postrst_hold%0d", c), bus.leds + 256 * bus.step, 8'h01);
        end
        edge_wait();
        chk("postrst_step_leds", bus.leds, 8'h02);
        chk("postrst_step", bus.step, 1);

        // randomized stimulus against the model
        r_md  = 2'b00;
        r_per = 2;
        for (int i = 0; i < 600; i++) begin
            r_ld  = (i == 0) || ($urandom_range(0, 15) == 0);
            r_en  = ($urandom_range(0, 7) != 0);
            r_pat = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0) r_md = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) r_per = $urandom_range(0, 4);
            drive(r_en, r_md, r_ld, r_pat, 24'(r_per));
            model_edge(r_en, r_md, r_ld, int'(r_pat), r_per);
            edge_wait();
            chk($sformatf("rnd%0d_leds", i), bus.leds, m_leds);
            chk($sformatf("rnd%0d_step", i), bus.step, m_step);
            chk($sformatf("rnd%0d_dir",  i), bus.dir,  m_dir);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
